// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : FSM state encoding
//   RESET_PC_DEF  : default first fetch address
//   NOP_INSTR_DEF : ARMv8 NOP, shown in IF/ID while it holds a bubble
//   PC_INC        : sequential PC step
//   align_word    : clears address bits [1:0]
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hD503_201F;
  localparam logic [31:0] PC_INC        = 32'd4;

  // Masking rather than slicing keeps every bit of the input in use.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Holding register for a fetched word that arrived while the pipe was stalled.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   load_i              : capture pc_i/instr_i and mark full
//   clear_i             : empty the buffer (wins over load_i)
//   pc_i, instr_i       : PC and instruction to capture
//   pc_o, instr_o       : held PC and instruction
//   valid_o             : buffer holds a captured word
`timescale 1ns/1ps
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [63:0] data_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 64'd0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= {pc_i, instr_i};
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = data_q[63:32];
  assign instr_o = data_q[31:0];
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// loads IF/ID, holds a stalled response in a skid buffer, redirects on branch.
// Ports:
//   clk, Reset                      : clock, async active-low reset
//   Stall                           : hold IF/ID and PC
//   Branch_Taken, Branch_Target     : redirect pulse and target
//   Imem_Req, Imem_Addr             : memory request (registered)
//   Imem_Data, Imem_Valid           : memory response
//   IFID_PC, IFID_Instr, IFID_Valid : IF/ID pipeline register
//
// state    | meaning
// BOOT     | one idle cycle after reset release, no request
// FETCH    | request outstanding at PC
// HOLD     | response captured in skid buffer, waiting for Stall to drop
// DRAIN    | redirected with a request in flight; discard its response
`timescale 1ns/1ps
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic        Imem_Valid,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_q;
  logic [31:0]  ifid_pc_q;
  logic [31:0]  ifid_instr_q;
  logic         ifid_valid_q;

  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;
  logic         skid_valid;

  assign skid_load  = (state_q == ST_FETCH) && Imem_Valid && Stall && !Branch_Taken;
  assign skid_clear = Branch_Taken || ((state_q == ST_HOLD) && !Stall);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (Reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (Imem_Data),
    .pc_o    (skid_pc),
    .instr_o (skid_instr),
    .valid_o (skid_valid)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (Branch_Taken) begin
      pc_q         <= align_word(Branch_Target);
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      // A request still in flight must have its response swallowed.
      if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !Imem_Valid) begin
        state_q <= ST_DRAIN;
        req_q   <= 1'b0;
      end else begin
        state_q <= ST_FETCH;
        req_q   <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (Imem_Valid) begin
            if (!Stall) begin
              ifid_pc_q    <= pc_q;
              ifid_instr_q <= Imem_Data;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_q + PC_INC;
            end else begin
              state_q <= ST_HOLD;
              req_q   <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!Stall) begin
            ifid_pc_q    <= skid_pc;
            ifid_instr_q <= skid_instr;
            ifid_valid_q <= skid_valid;
            pc_q         <= pc_q + PC_INC;
            state_q      <= ST_FETCH;
            req_q        <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (Imem_Valid) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_Req   = req_q;
  assign Imem_Addr  = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_Instr = ifid_instr_q;
  assign IFID_Valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = 32'd0;
  logic [31:0] Imem_Data = 32'd0;
  logic        Imem_Valid = 1'b0;

  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_ifid_pc;
  logic [31:0] w_ifid_instr;
  logic        w_ifid_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] ins [0:2] = '{32'h8B02_0020, 32'hF940_0041, 32'hD280_0063};

  fetch_stage dut (
    .clk(clk), .Reset(Reset), .Stall(Stall),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Data(Imem_Data), .Imem_Valid(Imem_Valid),
    .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .Reset(Reset), .Stall(Stall),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Imem_Req(w_req), .Imem_Addr(w_addr),
    .Imem_Data(Imem_Data), .Imem_Valid(Imem_Valid),
    .IFID_PC(w_ifid_pc), .IFID_Instr(w_ifid_instr), .IFID_Valid(w_ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] d, input logic s);
    Imem_Valid = 1'b1;
    Imem_Data  = d;
    Stall      = s;
    step();
    Imem_Valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Imem_Valid = 1'b0;
    step();
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    step();
    checks++; if (Imem_Req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h expected 0", Imem_Req); end
    checks++; if (Imem_Addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", Imem_Addr); end
    checks++; if (IFID_PC !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc: got %h expected 00000000", IFID_PC); end
    checks++; if (IFID_Instr !== 32'hD503_201F) begin errors++; $display("FAIL rst_ifid_instr: got %h expected d503201f", IFID_Instr); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL rst_ifid_valid: got %0h expected 0", IFID_Valid); end
    checks++; if (dut.state_q !== ST_BOOT) begin errors++; $display("FAIL rst_state: got %0d expected 0", dut.state_q); end
    Reset = 1'b1;
    #1;
    checks++; if (Imem_Req !== 1'b0) begin errors++; $display("FAIL boot_req: got %0h expected 0", Imem_Req); end
    step();
    checks++; if (dut.state_q !== ST_FETCH) begin errors++; $display("FAIL boot_state: got %0d expected 1", dut.state_q); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      checks++; if (Imem_Req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %0h expected 1", i, Imem_Req); end
      checks++; if (Imem_Addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, Imem_Addr, 32'(i * 4)); end
      step();
      respond(ins[i], 1'b0);
      checks++; if (IFID_PC !== 32'(i * 4)) begin errors++; $display("FAIL seq_ifid_pc[%0d]: got %h expected %h", i, IFID_PC, 32'(i * 4)); end
      checks++; if (IFID_Instr !== ins[i]) begin errors++; $display("FAIL seq_ifid_instr[%0d]: got %h expected %h", i, IFID_Instr, ins[i]); end
      checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL seq_ifid_valid[%0d]: got %0h expected 1", i, IFID_Valid); end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    step();
    step(); respond(ins[0], 1'b0);
    step(); respond(ins[1], 1'b0);
    step(); respond(ins[2], 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (dut.state_q !== ST_HOLD) begin errors++; $display("FAIL hold_state[%0d]: got %0d expected 2", c, dut.state_q); end
      checks++; if (Imem_Req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %0h expected 0", c, Imem_Req); end
      checks++; if (IFID_PC !== 32'h4 || IFID_Instr !== ins[1]) begin errors++; $display("FAIL hold_ifid[%0d]: got %h/%h expected 00000004/%h", c, IFID_PC, IFID_Instr, ins[1]); end
      if (c < 2) step();
    end
    Stall = 1'b0;
    step();
    checks++; if (IFID_PC !== 32'h8 || IFID_Instr !== ins[2] || IFID_Valid !== 1'b1) begin errors++; $display("FAIL unhold_ifid: got %h/%h/%0h expected 00000008/%h/1", IFID_PC, IFID_Instr, IFID_Valid, ins[2]); end
    checks++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'hC) begin errors++; $display("FAIL unhold_req: got %0h/%h expected 1/0000000c", Imem_Req, Imem_Addr); end
  endtask

  task automatic test_branch_drain();
    step(); respond(32'h1234_5678, 1'b0);
    checks++; if (Imem_Addr !== 32'h10) begin errors++; $display("FAIL drain_pre_addr: got %h expected 00000010", Imem_Addr); end
    step();
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0103;
    step();
    Branch_Taken = 1'b0;
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0h expected 0", IFID_Valid); end
    checks++; if (IFID_Instr !== 32'hD503_201F) begin errors++; $display("FAIL drain_instr: got %h expected d503201f", IFID_Instr); end
    checks++; if (dut.state_q !== ST_DRAIN || Imem_Req !== 1'b0) begin errors++; $display("FAIL drain_state: got %0d/%0h expected 3/0", dut.state_q, Imem_Req); end
    respond(32'h0BAD_0BAD, 1'b0);
    checks++; if (dut.state_q !== ST_FETCH || Imem_Req !== 1'b1 || Imem_Addr !== 32'h100) begin errors++; $display("FAIL drain_exit: got %0d/%0h/%h expected 1/1/00000100", dut.state_q, Imem_Req, Imem_Addr); end
    checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 32'hD503_201F) begin errors++; $display("FAIL drain_discard: got %0h/%h expected 0/d503201f", IFID_Valid, IFID_Instr); end
  endtask

  task automatic test_branch_with_valid();
    step();
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0200;
    Imem_Valid = 1'b1; Imem_Data = 32'hDEAD_BEEF; Stall = 1'b1;
    step();
    Branch_Taken = 1'b0; Imem_Valid = 1'b0; Stall = 1'b0;
    checks++; if (dut.state_q !== ST_FETCH) begin errors++; $display("FAIL bv_state: got %0d expected 1", dut.state_q); end
    checks++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h200) begin errors++; $display("FAIL bv_req: got %0h/%h expected 1/00000200", Imem_Req, Imem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL bv_valid: got %0h expected 0", IFID_Valid); end
  endtask

  task automatic test_branch_in_hold();
    step(); respond(32'h1111_1111, 1'b1);
    checks++; if (dut.state_q !== ST_HOLD) begin errors++; $display("FAIL bh_pre_state: got %0d expected 2", dut.state_q); end
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0304;
    step();
    Branch_Taken = 1'b0;
    checks++; if (dut.state_q !== ST_FETCH || Imem_Req !== 1'b1 || Imem_Addr !== 32'h304) begin errors++; $display("FAIL bh_redirect: got %0d/%0h/%h expected 1/1/00000304", dut.state_q, Imem_Req, Imem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL bh_flush: got %0h expected 0", IFID_Valid); end
    Stall = 1'b0;
    step(); respond(32'h2222_2222, 1'b0);
    checks++; if (IFID_PC !== 32'h304 || IFID_Instr !== 32'h2222_2222 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL bh_next: got %h/%h/%0h expected 00000304/22222222/1", IFID_PC, IFID_Instr, IFID_Valid); end
  endtask

  task automatic test_branch_in_drain();
    step();
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0400;
    step();
    checks++; if (dut.state_q !== ST_DRAIN || Imem_Addr !== 32'h400) begin errors++; $display("FAIL bd_first: got %0d/%h expected 3/00000400", dut.state_q, Imem_Addr); end
    Branch_Target = 32'h0000_0501;
    step();
    Branch_Taken = 1'b0;
    checks++; if (dut.state_q !== ST_DRAIN || Imem_Req !== 1'b0 || Imem_Addr !== 32'h500) begin errors++; $display("FAIL bd_second: got %0d/%0h/%h expected 3/0/00000500", dut.state_q, Imem_Req, Imem_Addr); end
    respond(32'h0BAD_0BAD, 1'b0);
    checks++; if (dut.state_q !== ST_FETCH || Imem_Req !== 1'b1 || Imem_Addr !== 32'h500) begin errors++; $display("FAIL bd_exit: got %0d/%0h/%h expected 1/1/00000500", dut.state_q, Imem_Req, Imem_Addr); end
  endtask

  task automatic test_reset_mid_request();
    step();
    Reset = 1'b0;
    #1;
    checks++; if (Imem_Req !== 1'b0 || Imem_Addr !== 32'h0) begin errors++; $display("FAIL mr_async: got %0h/%h expected 0/00000000", Imem_Req, Imem_Addr); end
    checks++; if (IFID_Valid !== 1'b0 || dut.state_q !== ST_BOOT) begin errors++; $display("FAIL mr_async_state: got %0h/%0d expected 0/0", IFID_Valid, dut.state_q); end
    step();
    Reset = 1'b1;
    Imem_Valid = 1'b1; Imem_Data = 32'h0BAD_0BAD;
    step();
    Imem_Valid = 1'b0;
    checks++; if (dut.state_q !== ST_FETCH || Imem_Req !== 1'b1 || Imem_Addr !== 32'h0) begin errors++; $display("FAIL mr_boot: got %0d/%0h/%h expected 1/1/00000000", dut.state_q, Imem_Req, Imem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL mr_ignored: got %0h expected 0", IFID_Valid); end
    step(); respond(32'h3333_3333, 1'b0);
    checks++; if (IFID_PC !== 32'h0 || IFID_Instr !== 32'h3333_3333 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL mr_first: got %h/%h/%0h expected 00000000/33333333/1", IFID_PC, IFID_Instr, IFID_Valid); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %0h/%h expected 1/fffffffc", w_req, w_addr); end
    step(); respond(32'h4444_4444, 1'b0);
    checks++; if (w_ifid_pc !== 32'hFFFF_FFFC || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_cross: got %h/%h expected fffffffc/00000000", w_ifid_pc, w_addr); end
    step(); respond(32'h5555_5555, 1'b0);
    checks++; if (w_ifid_pc !== 32'h0 || w_ifid_instr !== 32'h5555_5555 || w_addr !== 32'h4) begin errors++; $display("FAIL wrap_next: got %h/%h/%h expected 00000000/55555555/00000004", w_ifid_pc, w_ifid_instr, w_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch_drain();
    test_branch_with_valid();
    test_branch_in_hold();
    test_branch_in_drain();
    test_reset_mid_request();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
